fetch_stage: RTL and testbench

Instruction-fetch stage of the 5-stage MIPS pipeline. It owns the fetch PC, drives a single-outstanding-request instruction-memory port, and loads the IF/ID register whose `instrD` feeds the decode-stage controller and main/ALU decoders. It handles variable memory latency, decode stalls (with a one-entry hold buffer) and branch/jump redirects resolved in decode. No branch delay slot: a redirect discards everything fetched after the redirecting instruction.

---
 rtl/fetch_stage_pkg.sv | 15 +
 rtl/fetch_stage_if.sv | 24 ++
 rtl/flopenrc.sv | 26 ++
 rtl/fetch_stage.sv | 111 +++++++++++
 tb/tb_fetch_stage.sv | 195 +++++++++++++++++++
 5 files changed

// File: rtl/fetch_stage_pkg.sv
// Shared definitions for the instruction-fetch stage: state encoding,
// bubble instruction and default boot address.
package fetch_stage_pkg;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        HOLD,
        DROP
    } fetch_state_e;

    localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'hBFC0_0000;

endpackage

// File: rtl/fetch_stage_if.sv
// Single-outstanding-request instruction-memory port.
// The fetch stage is the master; memory is the slave.
interface fetch_stage_if;

    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_ack;
    logic [31:0] inst_rdata;

    modport master (
        output inst_req,
        output inst_addr,
        input  inst_ack,
        input  inst_rdata
    );

    modport slave (
        input  inst_req,
        input  inst_addr,
        output inst_ack,
        output inst_rdata
    );

endinterface

// File: rtl/flopenrc.sv
// Enabled register with asynchronous active-low reset and synchronous clear.
// Clear only takes effect when the register is enabled.
module flopenrc #(
    parameter int unsigned Width = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clr,
    input  logic [Width-1:0] d,
    output logic [Width-1:0] q
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q <= '0;
        end else if (en) begin
            if (clr) begin
                q <= '0;
            end else begin
                q <= d;
            end
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// MIPS instruction-fetch stage: owns the fetch PC, drives the instruction-memory
// port and loads the IF/ID register, with a one-entry hold buffer for decode stalls.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          stallD,
    input  logic          redirect,
    input  logic [31:0]   redirect_pc,
    fetch_stage_if.master imem,
    output logic [31:0]   instrD,
    output logic [31:0]   pcplus4D,
    output logic          validD,
    output logic          fetch_wait
);

    fetch_state_e state_q;
    logic [31:0]  pcf_q;
    logic [31:0]  reqaddr_q;
    logic [31:0]  bufinstr_q;
    logic [31:0]  bufpc_q;

    logic [31:0]  target;
    logic [31:0]  pcf_plus4;
    logic         busy;
    logic         take;
    logic         bubble;
    logic [64:0]  ifid_d;
    logic [64:0]  ifid_q;

    assign target    = redirect_pc & 32'hFFFF_FFFC;
    assign pcf_plus4 = pcf_q + 32'd4;
    assign busy      = (state_q == FETCH) || (state_q == DROP);
    assign take      = (state_q == FETCH) && imem.inst_ack;

    assign imem.inst_req  = busy;
    assign imem.inst_addr = reqaddr_q;
    assign fetch_wait     = busy && !imem.inst_ack;

    // Anything other than a live word (fresh ack or buffered) becomes a bubble.
    assign bubble = redirect || !(take || (state_q == HOLD));
    assign ifid_d = (state_q == HOLD) ? {bufinstr_q, bufpc_q, 1'b1}
                                      : {imem.inst_rdata, pcf_plus4, 1'b1};

    flopenrc #(
        .Width (65)
    ) u_ifid (
        .clk (clk),
        .rst (rst),
        .en  (!stallD),
        .clr (bubble),
        .d   (ifid_d),
        .q   (ifid_q)
    );

    assign instrD   = ifid_q[64:33];
    assign pcplus4D = ifid_q[32:1];
    assign validD   = ifid_q[0];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            pcf_q      <= RESET_PC;
            reqaddr_q  <= RESET_PC;
            bufinstr_q <= NOP_INSTR;
            bufpc_q    <= 32'h0;
        end else if (redirect) begin
            pcf_q <= target;
            // An unanswered request must still complete before the target can go out.
            if (busy && !imem.inst_ack) begin
                state_q <= DROP;
            end else begin
                reqaddr_q <= target;
                state_q   <= FETCH;
            end
        end else begin
            unique case (state_q)
                IDLE: state_q <= FETCH;
                FETCH: begin
                    if (imem.inst_ack) begin
                        pcf_q <= pcf_plus4;
                        if (stallD) begin
                            bufinstr_q <= imem.inst_rdata;
                            bufpc_q    <= pcf_plus4;
                            state_q    <= HOLD;
                        end else begin
                            reqaddr_q <= pcf_plus4;
                        end
                    end
                end
                HOLD: begin
                    if (!stallD) begin
                        reqaddr_q <= pcf_q;
                        state_q   <= FETCH;
                    end
                end
                DROP: begin
                    if (imem.inst_ack) begin
                        reqaddr_q <= pcf_q;
                        state_q   <= FETCH;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: a table of per-cycle vectors from reset,
// followed by hand-written reset-abort and redirect-from-HOLD sequences.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stallD = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic [31:0] instrD;
    logic [31:0] pcplus4D;
    logic        validD;
    logic        fetch_wait;

    int n_cmp = 0;
    int n_err = 0;

    fetch_stage_if imem ();

    fetch_stage #(
        .RESET_PC (32'hBFC0_0000)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .stallD      (stallD),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .imem        (imem.master),
        .instrD      (instrD),
        .pcplus4D    (pcplus4D),
        .validD      (validD),
        .fetch_wait  (fetch_wait)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        stall;
        logic        redir;
        logic [31:0] rpc;
        logic        ack;
        logic [31:0] rdata;
        logic        req;    // expected before the edge
        logic [31:0] addr;
        logic        fwait;
        logic [31:0] instr;  // expected after the edge
        logic [31:0] pc4;
        logic        valid;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic s, input logic r, input logic [31:0] rpc, input logic a,
                       input logic [31:0] rd, input logic rq, input logic [31:0] ad,
                       input logic w, input logic [31:0] ins, input logic [31:0] p4,
                       input logic v);
        vec_t t;
        t.stall = s;  t.redir = r;  t.rpc = rpc;  t.ack = a;   t.rdata = rd;
        t.req = rq;   t.addr = ad;  t.fwait = w;  t.instr = ins; t.pc4 = p4; t.valid = v;
        vecs.push_back(t);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, ".req"},   {31'h0, imem.inst_req}, 32'h0);
        chk({tag, ".addr"},  imem.inst_addr, 32'hBFC0_0000);
        chk({tag, ".instr"}, instrD, 32'h0);
        chk({tag, ".pc4"},   pcplus4D, 32'h0);
        chk({tag, ".valid"}, {31'h0, validD}, 32'h0);
        chk({tag, ".wait"},  {31'h0, fetch_wait}, 32'h0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        imem.inst_ack   = 1'b0;
        imem.inst_rdata = 32'h0;

        // Stimulus table: pre-edge port checks, post-edge IF/ID checks.
        //   stall redir rpc           ack   rdata          req   addr           wait  instrD         pcplus4D       valid
        add(1'b0, 1'b0, 32'h0,         1'b0, 32'h0,         1'b0, 32'hBFC0_0000, 1'b0, 32'h0,         32'h0,         1'b0);
        add(1'b0, 1'b0, 32'h0,         1'b1, 32'hBFC0_0000, 1'b1, 32'hBFC0_0000, 1'b0, 32'hBFC0_0000, 32'hBFC0_0004, 1'b1);
        add(1'b0, 1'b0, 32'h0,         1'b1, 32'hBFC0_0004, 1'b1, 32'hBFC0_0004, 1'b0, 32'hBFC0_0004, 32'hBFC0_0008, 1'b1);
        add(1'b0, 1'b0, 32'h0,         1'b1, 32'hBFC0_0008, 1'b1, 32'hBFC0_0008, 1'b0, 32'hBFC0_0008, 32'hBFC0_000C, 1'b1);
        // two wait states
        add(1'b0, 1'b0, 32'h0,         1'b0, 32'h0,         1'b1, 32'hBFC0_000C, 1'b1, 32'h0,         32'h0,         1'b0);
        add(1'b0, 1'b0, 32'h0,         1'b0, 32'h0,         1'b1, 32'hBFC0_000C, 1'b1, 32'h0,         32'h0,         1'b0);
        add(1'b0, 1'b0, 32'h0,         1'b1, 32'h1111_0000, 1'b1, 32'hBFC0_000C, 1'b0, 32'h1111_0000, 32'hBFC0_0010, 1'b1);
        // stall for 3 cycles, ack in the first
        add(1'b1, 1'b0, 32'h0,         1'b1, 32'h2222_0000, 1'b1, 32'hBFC0_0010, 1'b0, 32'h1111_0000, 32'hBFC0_0010, 1'b1);
        add(1'b1, 1'b0, 32'h0,         1'b0, 32'h0,         1'b0, 32'hBFC0_0010, 1'b0, 32'h1111_0000, 32'hBFC0_0010, 1'b1);
        add(1'b1, 1'b0, 32'h0,         1'b1, 32'hDEAD_BEEF, 1'b0, 32'hBFC0_0010, 1'b0, 32'h1111_0000, 32'hBFC0_0010, 1'b1);
        add(1'b0, 1'b0, 32'h0,         1'b0, 32'h0,         1'b0, 32'hBFC0_0010, 1'b0, 32'h2222_0000, 32'hBFC0_0014, 1'b1);
        add(1'b0, 1'b0, 32'h0,         1'b1, 32'h3333_0000, 1'b1, 32'hBFC0_0014, 1'b0, 32'h3333_0000, 32'hBFC0_0018, 1'b1);
        // redirect with an outstanding request, stale ack two cycles later
        add(1'b0, 1'b1, 32'h0000_0103, 1'b0, 32'h0,         1'b1, 32'hBFC0_0018, 1'b1, 32'h0,         32'h0,         1'b0);
        add(1'b0, 1'b0, 32'h0,         1'b0, 32'h0,         1'b1, 32'hBFC0_0018, 1'b1, 32'h0,         32'h0,         1'b0);
        add(1'b0, 1'b0, 32'h0,         1'b1, 32'hBAD0_0000, 1'b1, 32'hBFC0_0018, 1'b0, 32'h0,         32'h0,         1'b0);
        add(1'b0, 1'b0, 32'h0,         1'b1, 32'h4444_0000, 1'b1, 32'h0000_0100, 1'b0, 32'h4444_0000, 32'h0000_0104, 1'b1);
        // redirect coincident with an ack
        add(1'b0, 1'b1, 32'h0000_0200, 1'b1, 32'h5555_0000, 1'b1, 32'h0000_0104, 1'b0, 32'h0,         32'h0,         1'b0);
        add(1'b0, 1'b0, 32'h0,         1'b1, 32'h6666_0000, 1'b1, 32'h0000_0200, 1'b0, 32'h6666_0000, 32'h0000_0204, 1'b1);
        // wrap-around at the top of the address space
        add(1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0,         1'b1, 32'h0000_0204, 1'b1, 32'h0,         32'h0,         1'b0);
        add(1'b0, 1'b0, 32'h0,         1'b1, 32'hBAD1_0000, 1'b1, 32'h0000_0204, 1'b0, 32'h0,         32'h0,         1'b0);
        add(1'b0, 1'b0, 32'h0,         1'b1, 32'h7777_0000, 1'b1, 32'hFFFF_FFFC, 1'b0, 32'h7777_0000, 32'h0000_0000, 1'b1);
        add(1'b0, 1'b0, 32'h0,         1'b1, 32'h8888_0000, 1'b1, 32'h0000_0000, 1'b0, 32'h8888_0000, 32'h0000_0004, 1'b1);

        // Power-on reset
        #2 rst = 1'b0;
        #1 chk_reset_outputs("por");
        tick();
        tick();
        chk_reset_outputs("por_held");
        rst = 1'b1;

        foreach (vecs[i]) begin
            stallD          = vecs[i].stall;
            redirect        = vecs[i].redir;
            redirect_pc     = vecs[i].rpc;
            imem.inst_ack   = vecs[i].ack;
            imem.inst_rdata = vecs[i].rdata;
            #1;
            chk($sformatf("v%0d.req", i),   {31'h0, imem.inst_req}, {31'h0, vecs[i].req});
            chk($sformatf("v%0d.addr", i),  imem.inst_addr, vecs[i].addr);
            chk($sformatf("v%0d.wait", i),  {31'h0, fetch_wait}, {31'h0, vecs[i].fwait});
            tick();
            chk($sformatf("v%0d.instr", i), instrD, vecs[i].instr);
            chk($sformatf("v%0d.pc4", i),   pcplus4D, vecs[i].pc4);
            chk($sformatf("v%0d.valid", i), {31'h0, validD}, {31'h0, vecs[i].valid});
        end
        stallD   = 1'b0;
        redirect = 1'b0;

        // Reset mid-transfer: request outstanding at 32'h4, then reset aborts it.
        imem.inst_ack = 1'b0;
        #1 chk("abort.pre_req", {31'h0, imem.inst_req}, 32'h1);
        rst = 1'b0;
        #1 chk_reset_outputs("abort");
        imem.inst_ack   = 1'b1;
        imem.inst_rdata = 32'hBAD2_0000;
        tick();
        chk_reset_outputs("abort_ack_ignored");
        imem.inst_ack = 1'b0;
        rst = 1'b1;
        #1 chk("rel.idle_req", {31'h0, imem.inst_req}, 32'h0);
        tick();
        chk("rel.first_req", {31'h0, imem.inst_req}, 32'h1);
        chk("rel.first_addr", imem.inst_addr, 32'hBFC0_0000);
        chk("rel.first_wait", {31'h0, fetch_wait}, 32'h1);
        imem.inst_ack   = 1'b1;
        imem.inst_rdata = 32'hC0DE_0000;
        tick();
        chk("rel.instr", instrD, 32'hC0DE_0000);
        chk("rel.pc4", pcplus4D, 32'hBFC0_0004);

        // Enter HOLD, then redirect from the idle port: buffered word is discarded.
        stallD          = 1'b1;
        imem.inst_rdata = 32'hAAAA_0000;
        tick();
        chk("hold.req", {31'h0, imem.inst_req}, 32'h0);
        chk("hold.instr", instrD, 32'hC0DE_0000);
        stallD        = 1'b0;
        redirect      = 1'b1;
        redirect_pc   = 32'h0000_0300;
        imem.inst_ack = 1'b0;
        tick();
        chk("hredir.valid", {31'h0, validD}, 32'h0);
        chk("hredir.instr", instrD, 32'h0);
        redirect = 1'b0;
        #1;
        chk("hredir.req", {31'h0, imem.inst_req}, 32'h1);
        chk("hredir.addr", imem.inst_addr, 32'h0000_0300);
        imem.inst_ack   = 1'b1;
        imem.inst_rdata = 32'hC0DE_0300;
        tick();
        chk("hredir.tgt_instr", instrD, 32'hC0DE_0300);
        chk("hredir.tgt_pc4", pcplus4D, 32'h0000_0304);
        chk("hredir.tgt_valid", {31'h0, validD}, 32'h1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
